// File: rtl/axil_native_pkg.sv
// Shared constants for the AXI4-Lite to native memory-port bridge:
// response codes, FSM state encoding and arbitration modes.
package axil_native_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WR    = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_BRESP = 3'd3;
  localparam logic [2:0] ST_RRESP = 3'd4;

  localparam int RR       = 0;
  localparam int WR_FIRST = 1;
  localparam int RD_FIRST = 2;

endpackage

// File: rtl/axil_native_arb.sv
// Read/write grant selection for the bridge. Combinational grant, with a
// last_grant flop that alternates contested grants in round-robin mode.
module axil_native_arb
  import axil_native_pkg::*;
#(
  parameter int PRIO_MODE = RR
) (
  input  logic clk,
  input  logic rst,
  input  logic req_en,
  input  logic wr_req,
  input  logic rd_req,
  output logic grant_wr,
  output logic grant_rd
);

  // High when the most recent grant went to the write side; resets to read.
  logic last_wr;

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (req_en) begin
      if (wr_req && rd_req) begin
        case (PRIO_MODE)
          WR_FIRST: grant_wr = 1'b1;
          RD_FIRST: grant_rd = 1'b1;
          default: begin
            if (last_wr) grant_rd = 1'b1;
            else         grant_wr = 1'b1;
          end
        endcase
      end else begin
        grant_wr = wr_req;
        grant_rd = rd_req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr <= 1'b0;
    end else if (grant_wr || grant_rd) begin
      last_wr <= grant_wr;
    end
  end

endmodule

// File: rtl/axil_native_bridge.sv
// AXI4-Lite slave to native valid/ready memory-port bridge with independent
// AW/W/AR holding registers, registered B/R responses and optional timeout.
module axil_native_bridge
  import axil_native_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int PRIO_MODE  = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  native_valid,
  input  logic                  native_ready,
  output logic [ADDR_WIDTH-1:0] native_addr,
  output logic [DATA_WIDTH-1:0] native_wdata,
  output logic [STRB_WIDTH-1:0] native_wstrb,
  input  logic [DATA_WIDTH-1:0] native_rdata
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

  logic                  en;
  logic                  aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [2:0]            state;
  logic [TW-1:0]         tcnt, tcnt_inc;
  logic                  timed_out;
  logic                  grant_wr, grant_rd;

  assign s_axil_awready = en && !aw_full;
  assign s_axil_wready  = en && !w_full;
  assign s_axil_arready = en && !ar_full;

  // Timeout fires on the cycle the count would reach TIMEOUT, so native_valid
  // is high for exactly TIMEOUT cycles.
  assign tcnt_inc  = tcnt + TW'(1);
  assign timed_out = (TIMEOUT > 0) && (tcnt_inc == TO_LIMIT);

  axil_native_arb #(
    .PRIO_MODE(PRIO_MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_en  (state == ST_IDLE),
    .wr_req  (aw_full && w_full),
    .rd_req  (ar_full),
    .grant_wr(grant_wr),
    .grant_rd(grant_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en            <= 1'b0;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      aw_addr       <= '0;
      ar_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      state         <= ST_IDLE;
      tcnt          <= '0;
      native_valid  <= 1'b0;
      native_addr   <= '0;
      native_wdata  <= '0;
      native_wstrb  <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= '0;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= '0;
      s_axil_rdata  <= '0;
    end else begin
      en <= 1'b1;

      if (s_axil_awvalid && s_axil_awready) begin
        aw_addr <= s_axil_awaddr;
        aw_full <= 1'b1;
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
        w_full <= 1'b1;
      end
      if (s_axil_arvalid && s_axil_arready) begin
        ar_addr <= s_axil_araddr;
        ar_full <= 1'b1;
      end

      // Full flags clear at native completion; the handshakes above cannot
      // coincide with that because ready is low while a register is full.
      case (state)
        ST_IDLE: begin
          if (grant_wr) begin
            native_valid <= 1'b1;
            native_addr  <= aw_addr;
            native_wdata <= w_data;
            native_wstrb <= w_strb;
            tcnt         <= '0;
            state        <= ST_WR;
          end else if (grant_rd) begin
            native_valid <= 1'b1;
            native_addr  <= ar_addr;
            native_wdata <= '0;
            native_wstrb <= '0;
            tcnt         <= '0;
            state        <= ST_RD;
          end
        end
        ST_WR: begin
          if (native_ready || timed_out) begin
            native_valid  <= 1'b0;
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= native_ready ? OKAY : SLVERR;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            state         <= ST_BRESP;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        ST_RD: begin
          if (native_ready || timed_out) begin
            native_valid  <= 1'b0;
            s_axil_rvalid <= 1'b1;
            s_axil_rresp  <= native_ready ? OKAY : SLVERR;
            s_axil_rdata  <= native_ready ? native_rdata : '0;
            ar_full       <= 1'b0;
            state         <= ST_RRESP;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        ST_BRESP: begin
          if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_RRESP: begin
          if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
